// File: rtl/lb_uart_pkg.sv
// Shared definitions for the lb UART receive and transmit cores.
// Holds the bit counter width and the receiver state encoding.
package lb_uart_pkg;

    localparam int BAUD_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/lb_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops reset to RST_VAL so an idle line stays idle through reset.
module lb_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lb_uart_rx_core.sv
// UART receiver: mid-bit sampling, 7/8 data bits, optional parity,
// framing/overrun detection and break handling.
module lb_uart_rx_core
    import lb_uart_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic [BAUD_W-1:0] baud_value,
    input  logic              bit8,
    input  logic              parity_en,
    input  logic              odd_n_even,
    input  logic              rd,
    output logic [7:0]        data,
    output logic              rx_rdy,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun_err
);

    logic              rx_s;
    rx_state_t         state;
    rx_state_t         state_n;
    logic [BAUD_W-1:0] cnt;
    logic [BAUD_W-1:0] cnt_n;
    logic [BAUD_W-1:0] half_baud;
    logic [3:0]        bit_cnt;
    logic [3:0]        bit_cnt_n;
    logic [3:0]        last_bit;
    logic [7:0]        shreg;
    logic              cfg_bit8;
    logic              cfg_par_en;
    logic              cfg_odd;
    logic              par_bad;
    logic              stop_bad;
    logic              done;
    logic              expire;
    logic              start_frame;
    logic              shift_bit;
    logic              take_par;
    logic              take_stop;

    lb_sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    assign half_baud = {1'b0, baud_value[BAUD_W-1:1]};
    assign expire    = (cnt <= BAUD_W'(1));
    assign last_bit  = cfg_bit8 ? 4'd7 : 4'd6;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_cnt_n   = bit_cnt;
        start_frame = 1'b0;
        shift_bit   = 1'b0;
        take_par    = 1'b0;
        take_stop   = 1'b0;
        // One sample per bit period; the counter reloads rather than wraps
        if (state != IDLE && state != BREAK) begin
            cnt_n = expire ? baud_value : cnt - BAUD_W'(1);
        end
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n     = START;
                    cnt_n       = half_baud;
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (expire) begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shift_bit = 1'b1;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == last_bit) begin
                        state_n = cfg_par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (expire) begin
                    take_par = 1'b1;
                    state_n  = STOP;
                end
            end
            STOP: begin
                if (expire) begin
                    take_stop = 1'b1;
                    state_n   = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg       <= '0;
            cfg_bit8    <= 1'b0;
            cfg_par_en  <= 1'b0;
            cfg_odd     <= 1'b0;
            par_bad     <= 1'b0;
            stop_bad    <= 1'b0;
            done        <= 1'b0;
            data        <= '0;
            rx_rdy      <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            done <= take_stop;
            if (start_frame) begin
                shreg      <= '0;
                cfg_bit8   <= bit8;
                cfg_par_en <= parity_en;
                cfg_odd    <= odd_n_even;
                par_bad    <= 1'b0;
            end
            if (shift_bit) begin
                shreg <= {rx_s, shreg[7:1]};
            end
            if (take_par) begin
                par_bad <= ((^shreg) ^ rx_s) != cfg_odd;
            end
            if (take_stop) begin
                stop_bad <= !rx_s;
            end
            // A 7-bit word ends up in shreg[7:1]
            if (done) begin
                data        <= cfg_bit8 ? shreg : {1'b0, shreg[7:1]};
                parity_err  <= cfg_par_en & par_bad;
                frame_err   <= stop_bad;
                rx_rdy      <= 1'b1;
                overrun_err <= rx_rdy & !rd;
            end else if (rd) begin
                rx_rdy      <= 1'b0;
                overrun_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lb_uart_rx_core.sv
// Self-checking bench for lb_uart_rx_core: directed frames plus
// randomized frames checked against a frame-level reference model.
module tb_lb_uart_rx_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [19:0] baud_value;
    logic        bit8;
    logic        parity_en;
    logic        odd_n_even;
    logic        rd;
    logic [7:0]  data;
    logic        rx_rdy;
    logic        parity_err;
    logic        frame_err;
    logic        overrun_err;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_data;
    logic        exp_perr;
    logic        exp_ferr;
    logic        m_rdy;
    logic        m_ovr;
    int          rdy_at;
    logic        aborted;
    logic [7:0]  snap_data;
    logic [3:0]  snap_flags;

    always #5 clk = ~clk;

    lb_uart_rx_core dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .baud_value (baud_value),
        .bit8       (bit8),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .rd         (rd),
        .data       (data),
        .rx_rdy     (rx_rdy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun_err(overrun_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int frame_lat();
        int nb;
        nb = (bit8 ? 8 : 7) + (parity_en ? 1 : 0) + 1;
        return 4 + int'(baud_value >> 1) + nb * int'(baud_value);
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_data"}, 32'(data), 32'(exp_data));
        chk({tag, "_perr"}, 32'(parity_err), 32'(exp_perr));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(exp_ferr));
        chk({tag, "_rdy"}, 32'(rx_rdy), 32'(m_rdy));
        chk({tag, "_ovr"}, 32'(overrun_err), 32'(m_ovr));
    endtask

    task automatic do_rd();
        rd = 1'b1;
        step(1);
        rd = 1'b0;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic send(input logic [7:0] val, input logic pflip,
                        input logic stp, input logic tail_lvl,
                        input int tail_clks, input int rd_cyc,
                        input int rst_cyc);
        logic [11:0] fb;
        logic [7:0]  w;
        logic        prev;
        int          n;
        int          cyc;
        int          lat;
        w = bit8 ? val : {1'b0, val[6:0]};
        fb = '1;
        n = 0;
        fb[n] = 1'b0;
        n++;
        for (int i = 0; i < (bit8 ? 8 : 7); i++) begin
            fb[n] = w[i];
            n++;
        end
        if (parity_en) begin
            fb[n] = (^w) ^ odd_n_even ^ pflip;
            n++;
        end
        fb[n] = stp;
        n++;
        lat = frame_lat();
        rdy_at = -1;
        aborted = 1'b0;
        prev = rx_rdy;
        cyc = 0;
        for (int k = 0; k < n * int'(baud_value) + tail_clks; k++) begin
            if (!aborted) begin
                rx = (k < n * int'(baud_value)) ?
                     fb[k / int'(baud_value)] : tail_lvl;
                rd = (cyc + 1 == rd_cyc);
                reset = (cyc + 1 == rst_cyc);
                step(1);
                cyc++;
                if (reset) begin
                    snap_data = data;
                    snap_flags = {rx_rdy, parity_err, frame_err, overrun_err};
                    reset = 1'b0;
                    rx = 1'b1;
                    aborted = 1'b1;
                end
                if (rx_rdy && !prev && rdy_at < 0) rdy_at = cyc;
                prev = rx_rdy;
            end
        end
        rd = 1'b0;
        if (aborted) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
            exp_data = '0;
            exp_perr = 1'b0;
            exp_ferr = 1'b0;
        end else begin
            exp_data = w;
            exp_perr = parity_en && pflip;
            exp_ferr = !stp;
            m_ovr = (rd_cyc == lat) ? 1'b0 : m_rdy;
            m_rdy = 1'b1;
        end
    endtask

    initial begin
        int  lat;
        logic want_rd;
        logic [7:0] v;
        reset = 1'b1;
        rx = 1'b1;
        rd = 1'b0;
        baud_value = 20'd4;
        bit8 = 1'b0;
        parity_en = 1'b1;
        odd_n_even = 1'b0;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        exp_data = '0;
        exp_perr = 1'b0;
        exp_ferr = 1'b0;
        step(3);
        reset = 1'b0;
        step(2);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_rdy", 32'(rx_rdy), 32'h0);
        chk("rst_perr", 32'(parity_err), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_ovr", 32'(overrun_err), 32'h0);

        lat = frame_lat();
        send(8'h6A, 1'b0, 1'b1, 1'b1, 10, -1, -1);
        chk("p_ok_data", 32'(data), 32'h6A);
        chk("p_ok_rdy", 32'(rx_rdy), 32'h1);
        chk("p_ok_perr", 32'(parity_err), 32'h0);
        chk("p_ok_ferr", 32'(frame_err), 32'h0);
        chk("p_ok_lat", 32'(rdy_at), 32'(lat));

        do_rd();
        send(8'h6A, 1'b1, 1'b1, 1'b1, 10, -1, -1);
        chk("p_bad_data", 32'(data), 32'h6A);
        chk("p_bad_perr", 32'(parity_err), 32'h1);
        do_rd();
        chk("rd_rdy", 32'(rx_rdy), 32'h0);
        chk("rd_perr_held", 32'(parity_err), 32'h1);

        bit8 = 1'b1;
        parity_en = 1'b0;
        send(8'hA5, 1'b0, 1'b0, 1'b0, 8, -1, -1);
        chk("brk_data", 32'(data), 32'hA5);
        chk("brk_ferr", 32'(frame_err), 32'h1);
        chk("brk_rdy", 32'(rx_rdy), 32'h1);
        do_rd();
        step(16);
        chk("brk_hold_rdy", 32'(rx_rdy), 32'h0);
        rx = 1'b1;
        step(8);
        send(8'h5A, 1'b0, 1'b1, 1'b1, 10, -1, -1);
        check_model("after_brk");
        chk("after_brk_val", 32'(data), 32'h5A);

        do_rd();
        send(8'h11, 1'b0, 1'b1, 1'b1, 10, -1, -1);
        send(8'h22, 1'b0, 1'b1, 1'b1, 10, -1, -1);
        chk("ovr_data", 32'(data), 32'h22);
        chk("ovr_flag", 32'(overrun_err), 32'h1);
        do_rd();
        chk("ovr_rd_rdy", 32'(rx_rdy), 32'h0);
        chk("ovr_rd_flag", 32'(overrun_err), 32'h0);

        send(8'h33, 1'b0, 1'b1, 1'b1, 10, -1, -1);
        send(8'h44, 1'b0, 1'b1, 1'b1, 10, frame_lat(), -1);
        chk("rdsame_data", 32'(data), 32'h44);
        chk("rdsame_rdy", 32'(rx_rdy), 32'h1);
        chk("rdsame_ovr", 32'(overrun_err), 32'h0);

        baud_value = 20'd8;
        do_rd();
        rx = 1'b0;
        step(1);
        rx = 1'b1;
        step(40);
        chk("glitch_rdy", 32'(rx_rdy), 32'h0);
        chk("glitch_data", 32'(data), 32'h44);

        parity_en = 1'b1;
        odd_n_even = 1'b1;
        send(8'h77, 1'b1, 1'b1, 1'b1, 14, -1, -1);
        check_model("pre_rst");
        parity_en = 1'b0;
        send(8'h3C, 1'b0, 1'b1, 1'b1, 14, -1, 4 * 8 + 3);
        chk("midrst_abort", 32'(aborted), 32'h1);
        chk("midrst_data", 32'(snap_data), 32'h0);
        chk("midrst_flags", 32'(snap_flags), 32'h0);
        step(16);
        check_model("post_rst_idle");
        send(8'h3C, 1'b0, 1'b1, 1'b1, 14, -1, -1);
        chk("post_rst_val", 32'(data), 32'h3C);
        check_model("post_rst");

        for (int f = 0; f < 10; f++) begin
            baud_value = 20'($urandom_range(4, 24));
            bit8 = 1'($urandom_range(0, 1));
            parity_en = 1'($urandom_range(0, 1));
            odd_n_even = 1'($urandom_range(0, 1));
            want_rd = 1'($urandom_range(0, 1));
            v = 8'($urandom_range(0, 255));
            if (want_rd) do_rd();
            lat = frame_lat();
            send(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'b1, int'(baud_value) + 6, -1, -1);
            check_model($sformatf("rnd%0d", f));
            if (want_rd) chk($sformatf("rnd%0d_lat", f), 32'(rdy_at), 32'(lat));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lb_uart_rx_core.md
LB_UART_RX_CORE -- requirements
Module: lb_uart_rx_core

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 rx  input  1  asynchronous serial line, idle high.
REQ-005 baud_value  input  20  clocks per bit period; legal range 4..2^20-1.
REQ-006 bit8  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-007 parity_en  input  1  1 = parity bit present after data.
REQ-008 odd_n_even  input  1  1 = odd parity, 0 = even parity.
REQ-009 rd  input  1  one-cycle strobe: consumer has taken data, clears rx_rdy and overrun_err.
REQ-010 data  output  8  received word, LSB first on line; data[7]=0 when bit8=0.
REQ-011 rx_rdy  output  1  valid word held in data.
REQ-012 parity_err  output  1  parity mismatch on the word in data.
REQ-013 frame_err  output  1  stop bit sampled low on the word in data.
REQ-014 overrun_err  output  1  a word was overwritten before rd.

Function
REQ-015 rx SHALL pass a 2-flop synchronizer; the FSM uses only the synchronized value (rx_s).
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-017 IDLE: on rx_s=0, load bit counter with baud_value>>1, latch bit8/parity_en/odd_n_even, go START; config changes mid-frame are ignored.
REQ-018 START: at counter expiry sample rx_s; 0 -> reload baud_value, go DATA; 1 -> glitch, go IDLE, no flags change.
REQ-019 DATA: at each expiry (every baud_value clocks) shift rx_s into data LSB-first; after 7 (bit8=0) or 8 (bit8=1) bits go PARITY if parity_en else STOP.
REQ-020 PARITY: at expiry compute XOR of data bits and sampled bit; mismatch when result != odd_n_even.
REQ-021 STOP: at expiry sample rx_s; frame completes on that cycle.
REQ-022 On completion, next clock: data, parity_err (0 if parity disabled), frame_err updated; rx_rdy=1.
REQ-023 Stop sampled 1 -> IDLE; stop sampled 0 -> BREAK, which waits for rx_s=1 before IDLE.
REQ-024 Completion with rx_rdy=1 and no rd the same cycle SHALL set overrun_err and overwrite data.
REQ-025 Completion and rd in the same cycle: new word latched, rx_rdy stays 1, overrun_err not set.
REQ-026 rd with no completion SHALL clear rx_rdy and overrun_err; parity_err/frame_err held until next word.
REQ-027 Latency: rx_rdy rises 1 clock after the mid-stop sample, i.e. start edge + 2 sync + (baud_value>>1) + N*baud_value + 1 clocks, N = data+parity+stop bits.
REQ-028 Bit counter SHALL be 20 bits, count down, no wrap (reload on expiry).

Reset
REQ-029 reset SHALL force IDLE, synchronizer flops to 1, counters 0, data=0, rx_rdy=0, parity_err=0, frame_err=0, overrun_err=0.
REQ-030 reset mid-frame SHALL abort the frame with no flag update; reception resumes on the next falling edge after release.

Structure
REQ-031 Shared package lb_uart_pkg SHALL hold BAUD_W=20 and the RX state enumeration (shared with the TX core).
REQ-032 Synchronizer SHALL be sub-module lb_sync_2ff (reset value parameterized, 1 here); remainder is a single FSM plus datapath.

Verification
REQ-033 baud_value=4, bit8=0, parity_en=1, even; send 0x6A (7 bits), parity 0, stop 1 -> data=0x6A, rx_rdy=1, parity_err=0, frame_err=0.
REQ-034 Same config, parity bit sent as 1 -> data=0x6A, parity_err=1.
REQ-035 bit8=1, parity_en=0, send 0xA5 with stop=0, line low 3 bit times -> data=0xA5, frame_err=1, no new frame until line high.
REQ-036 Two frames 0x11, 0x22 without rd -> data=0x22, overrun_err=1; rd -> rx_rdy=0, overrun_err=0.
REQ-037 rx low pulse of 1 clock (baud_value=8) -> returns IDLE, rx_rdy stays 0.
REQ-038 reset asserted during DATA bit 3 -> all outputs 0 next clock; following clean frame 0x3C received correctly.
